// File: rtl/bcd_serial_converter.sv
// Iterative double-dabble binary-to-packed-BCD converter with a start/busy/done handshake.
// Optional `BCD_LEADING_BLANK_EN adds a registered leading-zero blanking mask.
module bcd_serial_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_LEADING_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 load;
    logic                 shift_en;
    logic                 commit;
    logic [WIDTH-1:0]     shift_q;
    logic [BCD_W-1:0]     scratch_q;
    logic [BCD_W-1:0]     scratch_adj;
    logic [CNT_W-1:0]     count_q;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        busy     = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                commit  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One add-3 corrector per digit; digits never carry into each other.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign scratch_adj[4*g +: 4] = add3(scratch_q[4*g +: 4]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            bcd       <= '0;
            done      <= 1'b0;
        end else begin
            done <= commit;
            if (load) begin
                shift_q   <= bin;
                scratch_q <= '0;
                count_q   <= CNT_W'(WIDTH);
            end else if (shift_en) begin
                scratch_q <= {scratch_adj[BCD_W-2:0], shift_q[WIDTH-1]};
                shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
                count_q   <= count_q - CNT_W'(1);
            end
            if (commit) begin
                bcd <= scratch_q;
            end
        end
    end

`ifdef BCD_LEADING_BLANK_EN
    localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

    // Bit i is set when digit i and every digit above it are zero; the ones digit always shows.
    function automatic logic [DIGITS-1:0] lead_blank(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] b;
        logic              hz;
        b  = '0;
        hz = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            hz   = hz & (v[4*i +: 4] == 4'd0);
            b[i] = (i == 0) ? 1'b0 : hz;
        end
        return b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank <= BLANK_RST;
        end else if (commit) begin
            blank <= lead_blank(scratch_q);
        end
    end
`endif

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Self-checking bench for bcd_serial_converter: a timing/value model compared every cycle,
// plus directed conversions with literal expectations.
module tb_bcd_serial_converter;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BCD_W  = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  bin = '0;
    logic              busy;
    logic              done;
    logic [BCD_W-1:0]  bcd;
`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank;
`endif

    bcd_serial_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd)
`ifdef BCD_LEADING_BLANK_EN
        ,
        .blank (blank)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int busy_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [BCD_W-1:0] to_bcd(input int v);
        logic [BCD_W-1:0] r;
        int               t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] to_blank(input int v);
        logic [DIGITS-1:0] b;
        int                p;
        b = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return b;
    endfunction

    // Model: a request is accepted when idle; its result appears WIDTH+1 edges later.
    logic              m_busy = 1'b0;
    int                m_left = 0;
    int                m_val = 0;
    logic [BCD_W-1:0]  exp_bcd = '0;
    logic              exp_done = 1'b0;
    logic [DIGITS-1:0] exp_blank = {DIGITS{1'b1}} << 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    = 1'b0;
            m_left    = 0;
            exp_bcd   = '0;
            exp_done  = 1'b0;
            exp_blank = {DIGITS{1'b1}} << 1;
        end else begin
            cyc++;
            exp_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy    = 1'b0;
                    exp_bcd   = to_bcd(m_val);
                    exp_blank = to_blank(m_val);
                    exp_done  = 1'b1;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_val  = int'(bin);
                m_left = WIDTH + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(exp_done));
        check("bcd", 32'(bcd), 32'(exp_bcd));
`ifdef BCD_LEADING_BLANK_EN
        check("blank", 32'(blank), 32'(exp_blank));
`endif
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cycles++;
    end

    task automatic do_start(input int v);
        @(posedge clk);
        #2;
        bin   = WIDTH'(v);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 40);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, n);
        end
    endtask

    int t1, t2, dc0;

    initial begin
        // Reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h0);

        // 255: busy spans WIDTH+1 cycles, single done pulse
        busy_cycles = 0;
        dc0 = done_cnt;
        do_start(255);
        wait_done("t255");
        check("t255_bcd", 32'(bcd), 32'h255);
        repeat (3) @(negedge clk);
        check("t255_busy_cycles", 32'(busy_cycles), 32'(WIDTH + 1));
        check("t255_done_cnt", 32'(done_cnt - dc0), 32'd1);

        // Back-to-back 0 then 100, second start in the done cycle
        do_start(0);
        wait_done("t0");
        t1 = cyc;
        check("t0_bcd", 32'(bcd), 32'h000);
        bin   = 8'd100;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done("t100");
        t2 = cyc;
        check("t100_bcd", 32'(bcd), 32'h100);
        check("b2b_spacing", 32'(t2 - t1), 32'd10);

        // Start while busy ignored; bin change after acceptance ignored
        repeat (2) @(posedge clk);
        dc0 = done_cnt;
        do_start(7);
        repeat (2) @(posedge clk);
        #2;
        bin   = 8'd99;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done("t7");
        check("t7_bcd", 32'(bcd), 32'h007);
        repeat (15) @(negedge clk);
        check("t7_done_cnt", 32'(done_cnt - dc0), 32'd1);

        // Reset mid-conversion aborts without a done pulse
        dc0 = done_cnt;
        do_start(59);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        check("abort_bcd", 32'(bcd), 32'h0);
        check("abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc0), 32'd0);
        do_start(59);
        wait_done("t59");
        check("t59_bcd", 32'(bcd), 32'h059);

`ifdef BCD_LEADING_BLANK_EN
        do_start(7);
        wait_done("bl7");
        check("blank_7", 32'(blank), 32'b110);
        do_start(42);
        wait_done("bl42");
        check("blank_42", 32'(blank), 32'b100);
        do_start(0);
        wait_done("bl0");
        check("blank_0", 32'(blank), 32'b110);
        do_start(200);
        wait_done("bl200");
        check("blank_200", 32'(blank), 32'b000);
`endif

        // Full sweep of every input value
        for (int v = 0; v < (1 << WIDTH); v++) begin
            logic ok_digits;
            do_start(v);
            wait_done("sweep");
            ok_digits = 1'b1;
            for (int d = 0; d < DIGITS; d++) begin
                if (bcd[4*d +: 4] > 4'd9) ok_digits = 1'b0;
            end
            check("sweep_digits", 32'(ok_digits), 32'd1);
            check("sweep_value", 32'(bcd[3:0]) + 32'd10 * 32'(bcd[7:4]) + 32'd100 * 32'(bcd[11:8]),
                  32'(v));
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
